// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the K=3, rate-1/2 (7,5) ACS pipeline.
package viterbi_pkg;

  localparam int NUM_STATES = 4;

  // Encoder output {g0, g1} when input u is applied in state s = {u(t-1), u(t-2)}.
  function automatic logic [1:0] expected_pair(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  // Add, then clamp to 2^w - 1.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/viterbi_acs_stage.sv
// One registered trellis step: branch metrics, add-compare-select, renormalise,
// survivor update and pointer advance, all enabled by the global advance.
module viterbi_acs_stage
  import viterbi_pkg::*;
#(
  parameter int unsigned N_STAGES  = 5,
  parameter int unsigned METRIC_W  = 4,
  parameter int unsigned HIST_W    = 8,
  parameter int unsigned PTR_W     = $clog2(HIST_W),
  parameter int unsigned STAGE_IDX = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           refresh,
  input  logic                           advance,
  input  logic                           in_valid,
  input  logic [2*N_STAGES-1:0]          in_symbols,
  input  logic [NUM_STATES*METRIC_W-1:0] in_pm,
  input  logic [NUM_STATES*HIST_W-1:0]   in_hist,
  input  logic [PTR_W-1:0]               in_wptr,
  output logic                           out_valid,
  output logic [2*N_STAGES-1:0]          out_symbols,
  output logic [NUM_STATES*METRIC_W-1:0] out_pm,
  output logic [NUM_STATES*HIST_W-1:0]   out_hist,
  output logic [PTR_W-1:0]               out_wptr,
  output logic [NUM_STATES*METRIC_W-1:0] next_pm
);

  logic [1:0]                     pair;
  logic [NUM_STATES*METRIC_W-1:0] sel_pm;
  logic [NUM_STATES*HIST_W-1:0]   sel_hist;
  logic [NUM_STATES-1:0]          msb;

  assign pair = in_symbols[2*STAGE_IDX +: 2];

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_state
    // Next state n = {u, n0}; its predecessors are {n0, 0} and {n0, 1}.
    localparam int unsigned P0 = 2 * (n % 2);
    localparam int unsigned P1 = P0 + 1;
    localparam logic        U  = (n >= 2);

    logic [METRIC_W-1:0] c0, c1;
    logic                take_p1;
    logic [HIST_W-1:0]   h;

    assign c0 = METRIC_W'(sat_add(32'(in_pm[P0*METRIC_W +: METRIC_W]),
                                  32'(hamming2(pair, expected_pair(U, 2'(P0)))), METRIC_W));
    assign c1 = METRIC_W'(sat_add(32'(in_pm[P1*METRIC_W +: METRIC_W]),
                                  32'(hamming2(pair, expected_pair(U, 2'(P1)))), METRIC_W));
    assign take_p1 = (c1 < c0);
    assign sel_pm[n*METRIC_W +: METRIC_W] = take_p1 ? c1 : c0;
    assign msb[n] = sel_pm[n*METRIC_W + METRIC_W - 1];

    always_comb begin
      h = take_p1 ? in_hist[P1*HIST_W +: HIST_W] : in_hist[P0*HIST_W +: HIST_W];
      h[in_wptr] = U;
    end

    assign sel_hist[n*HIST_W +: HIST_W] = h;
  end

  // Subtracting the MSB weight is exact only when every metric carries it.
  always_comb begin
    next_pm = sel_pm;
    if (&msb) begin
      for (int n = 0; n < NUM_STATES; n++) begin
        next_pm[n*METRIC_W + METRIC_W - 1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_symbols <= '0;
      out_pm      <= '0;
      out_hist    <= '0;
      out_wptr    <= '0;
    end else begin
      if (refresh) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= in_valid;
      end
      if (advance) begin
        out_symbols <= in_symbols;
        out_pm      <= next_pm;
        out_hist    <= sel_hist;
        out_wptr    <= in_wptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/viterbi_acs_pipeline.sv
// N_STAGES-deep ACS pipeline with global-stall valid/ready flow control and a
// registered best-state output.
module viterbi_acs_pipeline
  import viterbi_pkg::*;
#(
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned METRIC_W = 4,
  parameter int unsigned HIST_W   = 8,
  parameter int unsigned PTR_W    = $clog2(HIST_W)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           refresh,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*N_STAGES-1:0]          in_symbols,
  input  logic [NUM_STATES*METRIC_W-1:0] in_pm,
  input  logic [NUM_STATES*HIST_W-1:0]   in_hist,
  input  logic [PTR_W-1:0]               in_wptr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_STATES*METRIC_W-1:0] out_pm,
  output logic [NUM_STATES*HIST_W-1:0]   out_hist,
  output logic [PTR_W-1:0]               out_wptr,
  output logic [1:0]                     out_best_state
);

  logic advance;

  logic [N_STAGES:0]              valid_c;
  logic [2*N_STAGES-1:0]          sym_c  [N_STAGES+1];
  logic [NUM_STATES*METRIC_W-1:0] pm_c   [N_STAGES+1];
  logic [NUM_STATES*HIST_W-1:0]   hist_c [N_STAGES+1];
  logic [PTR_W-1:0]               wptr_c [N_STAGES+1];
  logic [NUM_STATES*METRIC_W-1:0] npm_c  [N_STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign valid_c[0] = in_valid;
  assign sym_c[0]   = in_symbols;
  assign pm_c[0]    = in_pm;
  assign hist_c[0]  = in_hist;
  assign wptr_c[0]  = in_wptr;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    viterbi_acs_stage #(
      .N_STAGES (N_STAGES),
      .METRIC_W (METRIC_W),
      .HIST_W   (HIST_W),
      .PTR_W    (PTR_W),
      .STAGE_IDX(k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .refresh    (refresh),
      .advance    (advance),
      .in_valid   (valid_c[k]),
      .in_symbols (sym_c[k]),
      .in_pm      (pm_c[k]),
      .in_hist    (hist_c[k]),
      .in_wptr    (wptr_c[k]),
      .out_valid  (valid_c[k+1]),
      .out_symbols(sym_c[k+1]),
      .out_pm     (pm_c[k+1]),
      .out_hist   (hist_c[k+1]),
      .out_wptr   (wptr_c[k+1]),
      .next_pm    (npm_c[k])
    );

    if (k != N_STAGES - 1) begin : g_unused_npm
      logic unused_npm;
      assign unused_npm = ^npm_c[k];
    end
  end

  logic unused_sym;
  assign unused_sym = ^sym_c[N_STAGES];

  assign out_valid = valid_c[N_STAGES];
  assign out_pm    = pm_c[N_STAGES];
  assign out_hist  = hist_c[N_STAGES];
  assign out_wptr  = wptr_c[N_STAGES];

  // Best state is taken from the last stage's next metrics so it lines up with out_pm.
  logic [1:0]          best_d, best_q;
  logic [METRIC_W-1:0] best_pm;

  always_comb begin
    best_d  = 2'd0;
    best_pm = npm_c[N_STAGES-1][METRIC_W-1:0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (npm_c[N_STAGES-1][s*METRIC_W +: METRIC_W] < best_pm) begin
        best_pm = npm_c[N_STAGES-1][s*METRIC_W +: METRIC_W];
        best_d  = 2'(s);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= 2'd0;
    end else if (advance) begin
      best_q <= best_d;
    end
  end

  assign out_best_state = best_q;

endmodule

// File: doc/viterbi_acs_pipeline.md
# viterbi_acs_pipeline

Parametrised add-compare-select (ACS) pipeline for the 4-state, K=3, rate-1/2 Viterbi decoder (generators 7,5). It sits between the branch-metric/symbol front end and the survivor traceback. It advances path metrics and register-exchange survivor histories through N_STAGES trellis steps, one step per pipeline stage. Compared with the fixed five-stage chain, it adds:

- configurable depth and widths;
- saturating metric arithmetic with automatic renormalisation;
- valid/ready backpressure;
- a registered best-state output.

## Interface

Parameters:

- N_STAGES, default 5: trellis steps per pass, which equals the pipeline depth; must be 1 or more.
- METRIC_W, default 4: path-metric width; must be 3 or more.
- HIST_W, default 8: survivor history bits per state; must be a power of two.
- PTR_W, default $clog2(HIST_W): width of the history write pointer.

Ports:

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- refresh  in  1  synchronous flush: clears every stage valid bit.
- in_valid  in  1  input word present.
- in_ready  out  1  pipeline accepts a word this cycle.
- in_symbols  in  2*N_STAGES  received pairs; pair k is [2k+1:2k] and is consumed by stage k. Bit 2k+1 is the g0=7 bit; bit 2k is the g1=5 bit.
- in_pm  in  4*METRIC_W  starting path metrics; state s occupies slice s.
- in_hist  in  4*HIST_W  starting survivor histories; state s occupies slice s.
- in_wptr  in  PTR_W  history write position for stage 0.
- out_valid  out  1  result word present.
- out_ready  in  1  downstream accepts the result.
- out_pm  out  4*METRIC_W  path metrics after N_STAGES steps.
- out_hist  out  4*HIST_W  survivor histories after N_STAGES steps.
- out_wptr  out  PTR_W  equals in_wptr + N_STAGES, modulo HIST_W.
- out_best_state  out  2  index of the minimum out_pm; ties go to the lowest index.

## Operation

Trellis:

- State s = {s1,s0} = {u(t-1), u(t-2)}.
- Input u moves state s to next state n = {u, s1}.
- Expected output pair is {u^s1^s0, u^s0}.
- Next state n = {u, n0} has two predecessors: p0 = {n0,0} and p1 = {n0,1}.

Per stage k, for each next state n:

- Branch metric bm is the Hamming distance (0 to 2) between pair k and the expected output.
- Candidate metric c = pm[p] + bm, computed METRIC_W+1 bits wide, then saturated to 2^METRIC_W - 1.
- Select the smaller candidate; p0 wins ties.
- New history = history[selected predecessor], with the bit at the stage's write pointer replaced by u = n[1].
- Write pointer increments by 1 and wraps modulo HIST_W.

Renormalisation:

- After the select step, if every new metric has its MSB set, clear the MSB of all four metrics, i.e. subtract 2^(METRIC_W-1).
- This is exact, because every metric is at least 2^(METRIC_W-1).
- Otherwise the metrics pass through unchanged.

out_best_state:

- Computed in the last stage from the final (post-normalisation) metrics.
- Registered alongside out_pm.

## Timing

- Latency is N_STAGES cycles from in_valid && in_ready to out_valid, when there is no stall.
- Throughput is one word per cycle.
- Flow control is a global stall:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance is 0, every stage register holds its value.
  - in_valid with in_ready=0 is ignored; the source must hold the word.
- Each stage carries its own valid bit. A stage register loads whenever advance is 1; its valid bit takes the upstream valid.
- refresh:
  - Clears all valid bits at the next edge, even during a stall. That edge's input word is dropped.
  - Data registers may keep stale values.
- rst: asynchronously clears all registers to 0. This gives out_valid=0, out_pm=0, out_hist=0, out_wptr=0 and out_best_state=0.
  - in_ready is 1 from the cycle after reset.
  - Reset in mid-operation discards all words in flight.
- Pointer wrap: HIST_W-1 + 1 = 0, with no further effect.
- Simultaneous events:
  - out_ready=1 together with a full pipeline: the output drains and a new input is accepted in the same cycle.
  - refresh together with in_valid: refresh wins.

## Structure

- Package viterbi_pkg, containing:
  - NUM_STATES=4;
  - function expected_pair(u,s);
  - function hamming2(a,b);
  - saturating-add function sat_add(a,b,W).
- Sub-module viterbi_acs_stage: one registered trellis step, carrying symbols, metrics, histories, pointer and valid, with advance as its enable.
- Top level: a generate loop of N_STAGES instances of viterbi_acs_stage, the best-state comparator, and the handshake logic.

## Test plan

1. Defaults; in_pm={s00:0, s01:15, s10:15, s11:15}; symbols all 00; in_hist all 0xFF; in_wptr=0 -> after 5 cycles out_pm={0,3,2,3}, out_hist[s00]=0xE0, out_wptr=5, out_best_state=0.
2. N_STAGES=1, in_pm all 12, symbols 00 -> renormalised out_pm={s00:4, s01:5, s10:4, s11:5}, out_best_state=0 (tie between s00 and s10).
3. N_STAGES=1, in_pm all 15, symbols 11 -> every candidate saturates to 15, then renormalises -> out_pm all 7.
4. Defaults; in_wptr=6 -> out_wptr=3 (wrap), and history bits 6, 7, 0, 1 and 2 are overwritten.
5. Defaults; out_ready=0; stream 6 back-to-back words -> the first 5 are accepted; in_ready=0 once out_valid=1; the 6th is held. Then out_ready=1 -> words emerge in order, one per cycle, with none lost or duplicated.
6. With 3 words in flight: pulse refresh -> no out_valid. Separately, assert rst mid-stream -> all outputs 0 immediately and in_ready=1 after release.
